// File: rtl/rot_tile_buffer.sv
// Square pixel tile buffer: fills row-major, drains rotated 90 degrees (CW or CCW) row-major.
// Define ROT_TILE_DOUBLE_BUF_EN for two ping-pong tile banks; default build holds one tile.
module rot_tile_buffer #(
  parameter int TILE_DIM = 120,
  parameter int PIX_W    = 16,
  parameter int BEAT_PIX = 8
) (
  input  logic                      Clk,
  input  logic                      ResetL,
  input  logic                      Flush,
  input  logic                      RotationType,
  input  logic                      InValid,
  input  logic [PIX_W*BEAT_PIX-1:0] InData,
  output logic                      InReady,
  output logic                      OutValid,
  output logic [PIX_W*BEAT_PIX-1:0] OutData,
  input  logic                      OutReady,
  output logic                      BlockReceived,
  output logic                      BlockSent,
  output logic                      Busy
);

`ifdef ROT_TILE_DOUBLE_BUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  localparam int BEAT_W = PIX_W * BEAT_PIX;
  localparam int L      = TILE_DIM / BEAT_PIX;
  localparam int ROW_W  = TILE_DIM * PIX_W;
  localparam int DIM_W  = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
  localparam int LW     = (L > 1) ? $clog2(L) : 1;
  localparam int RW     = $clog2(ROW_W);

  // One packed tile row per entry so a whole input beat lands with a single part-select write.
  logic [ROW_W-1:0] memRow [NBANK][TILE_DIM];

  logic             started;
  logic [DIM_W-1:0] wrRow, rdRow;
  logic [LW-1:0]    wrCol, rdCol;
  logic             wrBank, rdBank;
  logic             full   [NBANK];
  logic             rotCcw [NBANK];
  logic             issuedAll;
  logic             anyFull;
  logic [BEAT_W-1:0] rdBeat_p0;
  logic [BEAT_W-1:0] outData_p1;
  logic             vld_p1, last_p1;
  logic             blockReceived, blockSent;

  logic inAccept, wrLast, outAccept, tileDone, issue, rdLast;

  // Single bank keeps input closed through the BlockSent cycle as well as the drain.
  assign InReady   = started && !full[wrBank] && !((NBANK == 1) && blockSent);
  assign inAccept  = InValid && InReady;
  assign wrLast    = (wrRow == DIM_W'(TILE_DIM - 1)) && (wrCol == LW'(L - 1));
  assign outAccept = vld_p1 && OutReady;
  assign tileDone  = outAccept && last_p1;
  assign issue     = full[rdBank] && !issuedAll && (!vld_p1 || OutReady);
  assign rdLast    = (rdRow == DIM_W'(TILE_DIM - 1)) && (rdCol == LW'(L - 1));

  always_comb begin
    anyFull = 1'b0;
    for (int b = 0; b < NBANK; b++) anyFull = anyFull | full[b];
  end

  assign Busy          = (wrRow != '0) || (wrCol != '0) || anyFull;
  assign OutValid      = vld_p1;
  assign OutData       = outData_p1;
  assign BlockReceived = blockReceived;
  assign BlockSent     = blockSent;

  always_ff @(posedge Clk) begin
    if (inAccept)
      memRow[wrBank][wrRow][RW'(int'(wrCol) * BEAT_W) +: BEAT_W] <= InData;
  end

  // Stage p0: gather one rotated output beat; every pixel shares a source column, rows differ.
  always_comb begin
    rdBeat_p0 = '0;
    for (int k = 0; k < BEAT_PIX; k++) begin
      if (rotCcw[rdBank])
        rdBeat_p0[k*PIX_W +: PIX_W] =
          memRow[rdBank][DIM_W'(int'(rdCol) * BEAT_PIX + k)]
                [RW'((TILE_DIM - 1 - int'(rdRow)) * PIX_W) +: PIX_W];
      else
        rdBeat_p0[k*PIX_W +: PIX_W] =
          memRow[rdBank][DIM_W'(TILE_DIM - 1 - (int'(rdCol) * BEAT_PIX + k))]
                [RW'(int'(rdRow) * PIX_W) +: PIX_W];
    end
  end

  // Stage p1: output register, held while the consumer stalls.
  always_ff @(posedge Clk) begin
    if (!ResetL || Flush) begin
      started       <= 1'b0;
      wrRow         <= '0;
      wrCol         <= '0;
      rdRow         <= '0;
      rdCol         <= '0;
      wrBank        <= 1'b0;
      rdBank        <= 1'b0;
      issuedAll     <= 1'b0;
      for (int b = 0; b < NBANK; b++) begin
        full[b]   <= 1'b0;
        rotCcw[b] <= 1'b0;
      end
      vld_p1        <= 1'b0;
      last_p1       <= 1'b0;
      outData_p1    <= '0;
      blockReceived <= 1'b0;
      blockSent     <= 1'b0;
    end else begin
      started       <= 1'b1;
      blockReceived <= inAccept && wrLast;
      blockSent     <= tileDone;

      if (inAccept) begin
        if (wrCol == LW'(L - 1)) begin
          wrCol <= '0;
          wrRow <= (wrRow == DIM_W'(TILE_DIM - 1)) ? '0 : wrRow + DIM_W'(1);
        end else begin
          wrCol <= wrCol + LW'(1);
        end
        if (wrLast) begin
          full[wrBank]   <= 1'b1;
          rotCcw[wrBank] <= RotationType;
          if (NBANK > 1) wrBank <= ~wrBank;
        end
      end

      if (tileDone) begin
        full[rdBank] <= 1'b0;
        issuedAll    <= 1'b0;
        if (NBANK > 1) rdBank <= ~rdBank;
      end

      if (issue) begin
        outData_p1 <= rdBeat_p0;
        vld_p1     <= 1'b1;
        last_p1    <= rdLast;
        if (rdCol == LW'(L - 1)) begin
          rdCol <= '0;
          rdRow <= (rdRow == DIM_W'(TILE_DIM - 1)) ? '0 : rdRow + DIM_W'(1);
        end else begin
          rdCol <= rdCol + LW'(1);
        end
        if (rdLast) issuedAll <= 1'b1;
      end else if (outAccept) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rot_tile_buffer.sv
// Scoreboard bench for rot_tile_buffer on an 8x8 tile of 16-bit pixels, 4 pixels per beat.
module tb_rot_tile_buffer;
  localparam int TD = 8;
  localparam int BP = 4;
  localparam int PW = 16;
  localparam int BW = PW * BP;
  localparam int L  = TD / BP;
  localparam int NB = TD * TD / BP;

  logic          Clk = 1'b0;
  logic          ResetL = 1'b0;
  logic          Flush = 1'b0;
  logic          RotationType = 1'b0;
  logic          InValid = 1'b0;
  logic [BW-1:0] InData = '0;
  logic          OutReady = 1'b0;
  logic          InReady, OutValid, BlockReceived, BlockSent, Busy;
  logic [BW-1:0] OutData;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rxPulses = 0;
  int txPulses = 0;
  int rxCycle = -1;
  int firstValid = -1;
  logic [BW-1:0] expQ[$];

  rot_tile_buffer #(.TILE_DIM(TD), .PIX_W(PW), .BEAT_PIX(BP)) dut (
    .Clk(Clk), .ResetL(ResetL), .Flush(Flush), .RotationType(RotationType),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
    .BlockReceived(BlockReceived), .BlockSent(BlockSent), .Busy(Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (BlockReceived) begin
      rxPulses <= rxPulses + 1;
      rxCycle  <= cyc;
    end
    if (BlockSent) txPulses <= txPulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [BW-1:0] make_beat(input int base, input int n);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < BP; k++) b[k*PW +: PW] = 16'(base + (n / L) * TD + (n % L) * BP + k);
    return b;
  endfunction

  // Output row j = m/L, column i = (m%L)*BP+k; CW reads in[TD-1-i][j], CCW reads in[i][TD-1-j].
  function automatic logic [BW-1:0] exp_beat(input int base, input bit ccw, input int m);
    logic [BW-1:0] b;
    int j, i, r, c;
    b = '0;
    j = m / L;
    for (int k = 0; k < BP; k++) begin
      i = (m % L) * BP + k;
      if (ccw) begin r = i; c = TD - 1 - j; end
      else begin r = TD - 1 - i; c = j; end
      b[k*PW +: PW] = 16'(base + r * TD + c);
    end
    return b;
  endfunction

  task automatic fill_tiles(input int base, input bit rot, input int nBeats);
    int n, guard, t;
    bit acc;
    n = 0;
    guard = 0;
    for (int tt = 0; tt < nBeats / NB; tt++)
      for (int m = 0; m < NB; m++) expQ.push_back(exp_beat(base + tt * 64, rot ^ (tt % 2 == 1), m));
    while (n < nBeats && guard < 4000) begin
      t = n / NB;
      InValid = 1'b1;
      InData = make_beat(base + t * 64, n % NB);
      RotationType = rot ^ (t % 2 == 1);
      acc = InReady;
      tick();
      guard++;
      if (acc) n++;
    end
    InValid = 1'b0;
    InData = '0;
    RotationType = ~rot;
    checks++;
    if (n != nBeats) begin
      errors++;
      $display("FAIL fill_timeout accepted %0d required %0d", n, nBeats);
    end
  endtask

  task automatic collect(input int nBeats, input int readyPct, input int maxCycles);
    int got, ran;
    bit rdy, heldV;
    logic [BW-1:0] heldD, exp;
    got = 0;
    ran = 0;
    heldV = 1'b0;
    heldD = '0;
    while (got < nBeats && ran < maxCycles) begin
      if (heldV) begin
        checks++;
        if (OutValid !== 1'b1 || OutData !== heldD) begin
          errors++;
          $display("FAIL stall_hold valid %0b data %h required 1 %h", OutValid, OutData, heldD);
        end
      end
      if (OutValid === 1'b1 && firstValid < 0) firstValid = cyc;
      rdy = ($urandom_range(99) < readyPct);
      OutReady = rdy;
      if (OutValid === 1'b1 && rdy) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat data %h required none", OutData);
        end else begin
          exp = expQ.pop_front();
          if (OutData !== exp) begin
            errors++;
            $display("FAIL beat_%0d data %h required %h", got, OutData, exp);
          end
        end
        got++;
      end
      heldV = (OutValid === 1'b1) && !rdy;
      heldD = OutData;
      tick();
      ran++;
    end
    OutReady = 1'b0;
    checks++;
    if (got != nBeats) begin
      errors++;
      $display("FAIL drain_timeout beats %0d required %0d", got, nBeats);
    end
  endtask

  task automatic test_reset();
    ResetL = 1'b0;
    repeat (3) tick();
    checks += 6;
    if (InReady !== 1'b0)       begin errors++; $display("FAIL rst_inready got %b required 0", InReady); end
    if (OutValid !== 1'b0)      begin errors++; $display("FAIL rst_outvalid got %b required 0", OutValid); end
    if (OutData !== '0)         begin errors++; $display("FAIL rst_outdata got %h required 0", OutData); end
    if (BlockReceived !== 1'b0) begin errors++; $display("FAIL rst_blockreceived got %b required 0", BlockReceived); end
    if (BlockSent !== 1'b0)     begin errors++; $display("FAIL rst_blocksent got %b required 0", BlockSent); end
    if (Busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got %b required 0", Busy); end
    ResetL = 1'b1;
    tick();
    checks++;
    if (InReady !== 1'b1) begin errors++; $display("FAIL rst_release_inready got %b required 1", InReady); end
  endtask

  task automatic test_cw();
    int rx0, tx0;
    bit expReady;
`ifdef ROT_TILE_DOUBLE_BUF_EN
    expReady = 1'b1;
`else
    expReady = 1'b0;
`endif
    rx0 = rxPulses;
    tx0 = txPulses;
    firstValid = -1;
    fill_tiles(0, 1'b0, NB);
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL cw_busy_full got %b required 1", Busy); end
    collect(NB, 100, 200);
    checks += 3;
    if (BlockSent !== 1'b1) begin errors++; $display("FAIL cw_blocksent got %b required 1", BlockSent); end
    if (Busy !== 1'b0)      begin errors++; $display("FAIL cw_busy_after got %b required 0", Busy); end
    if (InReady !== expReady) begin errors++; $display("FAIL cw_inready_sent got %b required %b", InReady, expReady); end
    tick();
    checks += 5;
    if (InReady !== 1'b1)   begin errors++; $display("FAIL cw_inready_after got %b required 1", InReady); end
    if (BlockSent !== 1'b0) begin errors++; $display("FAIL cw_blocksent_width got %b required 0", BlockSent); end
    if (rxPulses - rx0 != 1) begin errors++; $display("FAIL cw_rx_pulses got %0d required 1", rxPulses - rx0); end
    if (txPulses - tx0 != 1) begin errors++; $display("FAIL cw_tx_pulses got %0d required 1", txPulses - tx0); end
    if (firstValid - rxCycle != 1) begin
      errors++;
      $display("FAIL cw_first_valid_latency got %0d required 1", firstValid - rxCycle);
    end
  endtask

  task automatic test_ccw();
    int rx0, tx0;
    rx0 = rxPulses;
    tx0 = txPulses;
    fill_tiles(0, 1'b1, NB);
    collect(NB, 100, 200);
    tick();
    checks += 2;
    if (rxPulses - rx0 != 1) begin errors++; $display("FAIL ccw_rx_pulses got %0d required 1", rxPulses - rx0); end
    if (txPulses - tx0 != 1) begin errors++; $display("FAIL ccw_tx_pulses got %0d required 1", txPulses - tx0); end
  endtask

  task automatic test_random_ready();
    int tx0;
    tx0 = txPulses;
    fill_tiles(200, 1'b0, NB);
    collect(NB, 50, 400);
    tick();
    checks++;
    if (txPulses - tx0 != 1) begin errors++; $display("FAIL rand_tx_pulses got %0d required 1", txPulses - tx0); end
  endtask

  task automatic test_flush();
    int rx0;
    rx0 = rxPulses;
    fill_tiles(100, 1'b0, 10);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checks += 3;
    if (Busy !== 1'b0)     begin errors++; $display("FAIL flush_busy got %b required 0", Busy); end
    if (InReady !== 1'b0)  begin errors++; $display("FAIL flush_inready got %b required 0", InReady); end
    if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_outvalid got %b required 0", OutValid); end
    tick();
    tick();
    checks += 2;
    if (rxPulses != rx0)  begin errors++; $display("FAIL flush_rx_pulse got %0d required %0d", rxPulses, rx0); end
    if (InReady !== 1'b1) begin errors++; $display("FAIL flush_inready_after got %b required 1", InReady); end
    fill_tiles(300, 1'b1, NB);
    collect(NB, 100, 200);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_extra_beat got %b required 0", OutValid); end
      OutReady = 1'b1;
      tick();
    end
    OutReady = 1'b0;
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL flush_queue_left got %0d required 0", expQ.size()); end
  endtask

  task automatic test_back_to_back();
    int overlap, rx0, tx0;
    bit done;
    overlap = 0;
    done = 1'b0;
    rx0 = rxPulses;
    tx0 = txPulses;
    fork
      fill_tiles(500, 1'b0, 2 * NB);
      begin
        collect(2 * NB, 100, 600);
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 700 && !done; k++) begin
          if (OutValid === 1'b1 && InReady === 1'b1) overlap++;
          tick();
        end
      end
    join
    tick();
    checks += 4;
`ifdef ROT_TILE_DOUBLE_BUF_EN
    if (overlap == 0) begin errors++; $display("FAIL b2b_overlap got %0d required >0", overlap); end
`else
    if (overlap != 0) begin errors++; $display("FAIL b2b_overlap got %0d required 0", overlap); end
`endif
    if (rxPulses - rx0 != 2) begin errors++; $display("FAIL b2b_rx_pulses got %0d required 2", rxPulses - rx0); end
    if (txPulses - tx0 != 2) begin errors++; $display("FAIL b2b_tx_pulses got %0d required 2", txPulses - tx0); end
    if (expQ.size() != 0) begin errors++; $display("FAIL b2b_queue_left got %0d required 0", expQ.size()); end
  endtask

  task automatic test_reset_mid_drain();
    fill_tiles(400, 1'b1, NB);
    collect(5, 100, 100);
    ResetL = 1'b0;
    tick();
    checks += 4;
    if (OutValid !== 1'b0) begin errors++; $display("FAIL rmd_outvalid got %b required 0", OutValid); end
    if (Busy !== 1'b0)     begin errors++; $display("FAIL rmd_busy got %b required 0", Busy); end
    if (InReady !== 1'b0)  begin errors++; $display("FAIL rmd_inready got %b required 0", InReady); end
    if (OutData !== '0)    begin errors++; $display("FAIL rmd_outdata got %h required 0", OutData); end
    expQ.delete();
    ResetL = 1'b1;
    tick();
    checks += 2;
    if (InReady !== 1'b1)  begin errors++; $display("FAIL rmd_inready_release got %b required 1", InReady); end
    if (OutValid !== 1'b0) begin errors++; $display("FAIL rmd_outvalid_release got %b required 0", OutValid); end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_random_ready();
    test_flush();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
